// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg
// Shared types and constants for the UART command packet decoder.
// The optional checksum byte is enabled by defining UART_CMD_CHECKSUM_EN.

package uart_cmd_pkg;

    // Parser states: waiting for sync, then one state per payload byte.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MASK  = 2'd1,
        ST_FLAGS = 2'd2,
        ST_CSUM  = 2'd3
    } state_t;

    // Packet start marker used when the instantiating level does not override it.
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Bit of the flags byte that requests a trigger pulse.
    localparam int FLAG_TRIG = 0;

    // Width of the saturating error counter.
    localparam int ERR_CNT_W = 8;

    // Checksum carried in the optional fourth byte: XOR of mask and flags.
    function automatic logic [7:0] calc_csum(input logic [7:0] mask_byte,
                                             input logic [7:0] flags_byte);
        return mask_byte ^ flags_byte;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// cycle_timer
// Loadable up-counter with a terminal-count strobe.
// i_load restarts the count from zero and arms the timer. While armed the
// count advances by one per cycle; o_expire is high on the cycle whose edge
// brings the count to LIMIT, after which the timer disarms and holds.
// A load in the same cycle as expiry wins: the timer restarts and no expiry
// is reported.

module cycle_timer #(
    parameter int LIMIT = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    output logic o_expire,
    output logic o_active
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count_reg;
    logic         run_reg;

    // The edge that takes the count from LIMIT-1 to LIMIT is the expiry edge.
    assign o_expire = run_reg && !i_load && (count_reg == W'(LIMIT - 1));
    assign o_active = run_reg;

    // Count register: restart on load, advance while armed, stop at LIMIT.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            count_reg <= '0;
            run_reg   <= 1'b0;
        end else if (i_load) begin
            count_reg <= '0;
            run_reg   <= 1'b1;
        end else if (run_reg) begin
            count_reg <= count_reg + W'(1);
            if (o_expire) begin
                run_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder
// Parses framed command packets from the UART receiver byte stream:
//   SYNC, mask, flags [, checksum]
// and drives held channel outputs with a loss-of-link watchdog, a stretched
// trigger pulse, and error/status strobes.
// Build option: define UART_CMD_CHECKSUM_EN for 4-byte packets with an XOR
// checksum; otherwise packets are 3 bytes and commit on the flags byte.

module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int          NUM_CH       = 4,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int          BYTE_TIMEOUT = 50000,
    parameter int          HOLD_CYCLES  = 2500000,
    parameter int          PULSE_CYCLES = 25000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_done,
    input  logic [7:0]           i_data,
    output logic [NUM_CH-1:0]    o_ch,
    output logic                 o_trigger,
    output logic                 o_pkt_valid,
    output logic                 o_err,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

`ifdef UART_CMD_CHECKSUM_EN
    // The whole mask byte takes part in the checksum, so keep all of it.
    localparam int MASK_W = 8;
`else
    localparam int MASK_W = NUM_CH;
`endif

    state_t               state_reg;
    state_t               state_next;

    logic [MASK_W-1:0]    mask_reg;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]           flags_reg;
`endif

    logic [NUM_CH-1:0]    ch_reg;
    logic [NUM_CH-1:0]    ch_next;
    logic                 pkt_valid_reg;
    logic                 err_reg;
    logic [ERR_CNT_W-1:0] err_cnt_reg;

    // Decoded per-cycle events from the output process.
    logic                 commit;
    logic                 commit_trig;
    logic [NUM_CH-1:0]    commit_mask;
    logic                 err_evt;
    logic                 mask_load;
    logic                 flags_load;

    // Timer handshakes.
    logic                 byte_tmo_load;
    logic                 byte_tmo_expire;
    logic                 byte_tmo_active;
    logic                 hold_expire;
    logic                 hold_active;
    logic                 trig_load;
    logic                 trig_expire;
    logic                 trig_active;
    logic                 unused_timer_flags;

    // ------------------------------------------------------------------
    // Timers
    // ------------------------------------------------------------------

    // The inter-byte timer is parked at zero while idle and restarted by
    // every byte, so inside a packet it measures the gap since the last byte.
    assign byte_tmo_load = i_done || (state_reg == ST_IDLE);

    cycle_timer #(
        .LIMIT (BYTE_TIMEOUT)
    ) u_byte_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (byte_tmo_load),
        .o_expire (byte_tmo_expire),
        .o_active (byte_tmo_active)
    );

    // Hold watchdog: restarted by each commit, stops once it has fired.
    cycle_timer #(
        .LIMIT (HOLD_CYCLES)
    ) u_hold_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (commit),
        .o_expire (hold_expire),
        .o_active (hold_active)
    );

    // Trigger stretcher: its armed flag is the pulse itself, so a retrigger
    // restarts the full width without a gap.
    assign trig_load = commit && commit_trig;

    cycle_timer #(
        .LIMIT (PULSE_CYCLES)
    ) u_trig_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (trig_load),
        .o_expire (trig_expire),
        .o_active (trig_active)
    );

    // Status flags not needed by this level.
    assign unused_timer_flags = byte_tmo_active ^ hold_active ^ trig_expire;

    // ------------------------------------------------------------------
    // Packet FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: a byte always takes priority over a timeout.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_done && (i_data == SYNC_BYTE)) begin
                    state_next = ST_MASK;
                end
            end
            ST_MASK: begin
                // A sync value here is just mask data; no resync.
                if (i_done) begin
                    state_next = ST_FLAGS;
                end else if (byte_tmo_expire) begin
                    state_next = ST_IDLE;
                end
            end
            ST_FLAGS: begin
                if (i_done) begin
`ifdef UART_CMD_CHECKSUM_EN
                    state_next = ST_CSUM;
`else
                    state_next = ST_IDLE;
`endif
                end else if (byte_tmo_expire) begin
                    state_next = ST_IDLE;
                end
            end
`ifdef UART_CMD_CHECKSUM_EN
            ST_CSUM: begin
                if (i_done || byte_tmo_expire) begin
                    state_next = ST_IDLE;
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output decode: which byte is latched and whether the packet commits or fails.
    always_comb begin
        commit      = 1'b0;
        commit_trig = 1'b0;
        commit_mask = mask_reg[NUM_CH-1:0];
        err_evt     = 1'b0;
        mask_load   = 1'b0;
        flags_load  = 1'b0;
        case (state_reg)
            ST_MASK: begin
                if (i_done) begin
                    mask_load = 1'b1;
                end else if (byte_tmo_expire) begin
                    err_evt = 1'b1;
                end
            end
            ST_FLAGS: begin
                if (i_done) begin
`ifdef UART_CMD_CHECKSUM_EN
                    flags_load = 1'b1;
`else
                    commit      = 1'b1;
                    commit_trig = i_data[FLAG_TRIG];
`endif
                end else if (byte_tmo_expire) begin
                    err_evt = 1'b1;
                end
            end
`ifdef UART_CMD_CHECKSUM_EN
            ST_CSUM: begin
                if (i_done) begin
                    if (i_data == calc_csum(mask_reg, flags_reg)) begin
                        commit      = 1'b1;
                        commit_trig = flags_reg[FLAG_TRIG];
                    end else begin
                        err_evt = 1'b1;
                    end
                end else if (byte_tmo_expire) begin
                    err_evt = 1'b1;
                end
            end
`endif
            default: begin
                commit = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Payload capture and output registers
    // ------------------------------------------------------------------

    // Payload bytes held until the packet completes.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            mask_reg <= '0;
`ifdef UART_CMD_CHECKSUM_EN
            flags_reg <= '0;
`endif
        end else begin
            if (mask_load) begin
                mask_reg <= i_data[MASK_W-1:0];
            end
`ifdef UART_CMD_CHECKSUM_EN
            if (flags_load) begin
                flags_reg <= i_data;
            end
`endif
        end
    end

    // Per-channel next value: a commit beats a simultaneous watchdog expiry.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign ch_next[gi] = commit      ? commit_mask[gi] :
                             hold_expire ? 1'b0            :
                                           ch_reg[gi];
    end

    // Registered outputs: channel levels, strobes and saturating error count.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ch_reg        <= '0;
            pkt_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            ch_reg        <= ch_next;
            pkt_valid_reg <= commit;
            err_reg       <= err_evt;
            if (err_evt && (err_cnt_reg != {ERR_CNT_W{1'b1}})) begin
                err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
            end
        end
    end

    assign o_ch        = ch_reg;
    assign o_trigger   = trig_active;
    assign o_pkt_valid = pkt_valid_reg;
    assign o_err       = err_reg;
    assign o_err_cnt   = err_cnt_reg;

    // flags_load is only consumed when the checksum byte is present.
`ifndef UART_CMD_CHECKSUM_EN
    logic unused_flags_load;
    assign unused_flags_load = flags_load;
`endif

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder
// Directed scenarios followed by randomized packet traffic. A timestamp-based
// reference model (pending byte queue, commit/trigger deadlines) predicts
// every output after every clock edge.
// Honours UART_CMD_CHECKSUM_EN to match the packet length of the DUT build.

module tb_uart_cmd_decoder;

    localparam int         NUM_CH       = 4;
    localparam logic [7:0] SYNC         = 8'hA5;
    localparam int         BYTE_TIMEOUT = 40;
    localparam int         HOLD_CYCLES  = 400;
    localparam int         PULSE_CYCLES = 30;
`ifdef UART_CMD_CHECKSUM_EN
    localparam int         PKT_LEN      = 4;
`else
    localparam int         PKT_LEN      = 3;
`endif

    logic              i_clk;
    logic              i_rst_n;
    logic              i_done;
    logic [7:0]        i_data;
    logic [NUM_CH-1:0] o_ch;
    logic              o_trigger;
    logic              o_pkt_valid;
    logic              o_err;
    logic [7:0]        o_err_cnt;

    uart_cmd_decoder #(
        .NUM_CH       (NUM_CH),
        .SYNC_BYTE    (SYNC),
        .BYTE_TIMEOUT (BYTE_TIMEOUT),
        .HOLD_CYCLES  (HOLD_CYCLES),
        .PULSE_CYCLES (PULSE_CYCLES)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_done      (i_done),
        .i_data      (i_data),
        .o_ch        (o_ch),
        .o_trigger   (o_trigger),
        .o_pkt_valid (o_pkt_valid),
        .o_err       (o_err),
        .o_err_cnt   (o_err_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Counters
    int check_cnt = 0;
    int pass_cnt  = 0;

    // Reference model state
    int          now        = 0;
    logic [7:0]  pkt_q[$];
    int          last_byte  = 0;
    int          hold_dl    = -1;
    int          trig_until = 0;
    logic [NUM_CH-1:0] exp_ch  = '0;
    logic [7:0]  exp_cnt    = '0;
    logic        exp_pkt    = 1'b0;
    logic        exp_err    = 1'b0;
    logic        exp_trig   = 1'b0;

    // Trigger pulse length tracking
    int trig_run = 0;
    int last_run = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, now);
        end
    endtask

    // Predicts the outputs after the edge numbered 'now'.
    task automatic model_edge(input logic rst_n_v, input logic done_v, input logic [7:0] data_v);
        bit committed;
        bit ok;
        committed = 0;
        exp_pkt   = 1'b0;
        exp_err   = 1'b0;
        if (!rst_n_v) begin
            pkt_q.delete();
            exp_ch     = '0;
            exp_cnt    = '0;
            hold_dl    = -1;
            trig_until = 0;
        end else begin
            if (pkt_q.size() > 0 && !done_v && (now - last_byte) == BYTE_TIMEOUT) begin
                exp_err = 1'b1;
                if (exp_cnt != 8'd255) exp_cnt++;
                pkt_q.delete();
            end
            if (done_v) begin
                last_byte = now;
                if (pkt_q.size() == 0) begin
                    if (data_v == SYNC) pkt_q.push_back(data_v);
                end else begin
                    pkt_q.push_back(data_v);
                    if (pkt_q.size() == PKT_LEN) begin
                        ok = 1;
                        if (PKT_LEN == 4) ok = (pkt_q[PKT_LEN-1] == (pkt_q[1] ^ pkt_q[2]));
                        if (ok) begin
                            committed = 1;
                            exp_pkt   = 1'b1;
                            exp_ch    = pkt_q[1][NUM_CH-1:0];
                            hold_dl   = now + HOLD_CYCLES;
                            if (pkt_q[2][0]) trig_until = now + PULSE_CYCLES;
                        end else begin
                            exp_err = 1'b1;
                            if (exp_cnt != 8'd255) exp_cnt++;
                        end
                        pkt_q.delete();
                    end
                end
            end
            if (!committed && hold_dl >= 0 && now == hold_dl) exp_ch = '0;
        end
        exp_trig = (now < trig_until);
    endtask

    // One clock: drive inputs, advance the model, compare all outputs.
    task automatic tick(input logic rst_n_v, input logic done_v, input logic [7:0] data_v);
        i_rst_n = rst_n_v;
        i_done  = done_v;
        i_data  = data_v;
        @(posedge i_clk);
        now++;
        model_edge(rst_n_v, done_v, data_v);
        #1;
        check("ch",        32'(o_ch),        32'(exp_ch));
        check("trigger",   32'(o_trigger),   32'(exp_trig));
        check("pkt_valid", 32'(o_pkt_valid), 32'(exp_pkt));
        check("err",       32'(o_err),       32'(exp_err));
        check("err_cnt",   32'(o_err_cnt),   32'(exp_cnt));
        if (o_trigger) begin
            trig_run++;
        end else begin
            if (trig_run != 0) last_run = trig_run;
            trig_run = 0;
        end
        i_done = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b1, 1'b0, 8'h00);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        idle(gap);
        tick(1'b1, 1'b1, b);
    endtask

    task automatic send_pkt(input logic [7:0] mask, input logic [7:0] flags, input bit bad, input int gap);
        send_byte(SYNC, gap);
        send_byte(mask, gap);
        send_byte(flags, gap);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte((mask ^ flags) ^ (bad ? 8'h5A : 8'h00), gap);
`endif
        $display("pkt mask=%02h flags=%02h bad_csum=%0d gap=%0d cycle=%0d ch=%0h err_cnt=%0d",
                 mask, flags, bad, gap, now, o_ch, o_err_cnt);
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_done  = 1'b0;
        i_data  = 8'h00;

        // Reset state
        tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);
        check("rst_ch", 32'(o_ch), 32'h0);
        check("rst_err_cnt", 32'(o_err_cnt), 32'h0);
        check("rst_trigger", 32'(o_trigger), 32'h0);
        $display("reset applied cycle=%0d", now);

`ifdef UART_CMD_CHECKSUM_EN
        // Bad checksum then a good one
        send_byte(SYNC, 4); send_byte(8'h03, 4); send_byte(8'h00, 4); send_byte(8'hFF, 4);
        check("csum_bad_err", 32'(o_err), 32'h1);
        check("csum_bad_cnt", 32'(o_err_cnt), 32'h1);
        check("csum_bad_ch", 32'(o_ch), 32'h0);
        $display("bad checksum packet cycle=%0d err_cnt=%0d", now, o_err_cnt);
        send_byte(SYNC, 4); send_byte(8'h03, 4); send_byte(8'h00, 4); send_byte(8'h03, 4);
        check("csum_good_ch", 32'(o_ch), 32'h3);
        $display("good checksum packet cycle=%0d ch=%0h", now, o_ch);
`endif

        // Basic packet with trigger
        last_run = 0;
        send_pkt(8'h05, 8'h01, 1'b0, 10);
        check("basic_ch", 32'(o_ch), 32'h5);
        check("basic_valid", 32'(o_pkt_valid), 32'h1);
        check("basic_trig", 32'(o_trigger), 32'h1);
        idle(PULSE_CYCLES + 5);
        check("trig_width", 32'(last_run), 32'(PULSE_CYCLES));

        // Inter-byte timeout, then a stray byte is dropped
        send_byte(SYNC, 3);
        send_byte(8'h0F, 3);
        idle(BYTE_TIMEOUT - 1);
        check("tmo_early", 32'(o_err), 32'h0);
        idle(1);
        check("tmo_err", 32'(o_err), 32'h1);
        $display("timeout packet cycle=%0d err_cnt=%0d", now, o_err_cnt);
        idle(1);
        send_byte(8'h0F, 3);
        check("stray_err", 32'(o_err), 32'h0);
        check("stray_valid", 32'(o_pkt_valid), 32'h0);

        // Hold watchdog expiry
        send_pkt(8'h0A, 8'h00, 1'b0, 2);
        begin
            int hold_len;
            hold_len = 0;
            for (int k = 1; k <= HOLD_CYCLES + 10; k++) begin
                idle(1);
                if (o_ch == '0) begin
                    hold_len = k;
                    break;
                end
            end
            check("hold_len", 32'(hold_len), 32'(HOLD_CYCLES));
        end

        // Refresh one cycle before expiry keeps the channels held
        send_pkt(8'h0C, 8'h00, 1'b0, 0);
        idle(HOLD_CYCLES - 1 - PKT_LEN);
        send_pkt(8'h0C, 8'h00, 1'b0, 0);
        check("refresh_ch", 32'(o_ch), 32'hC);
        idle(1);
        check("refresh_hold", 32'(o_ch), 32'hC);

        // Retrigger half way through the pulse
        idle(5);
        last_run = 0;
        send_pkt(8'h01, 8'h01, 1'b0, 0);
        idle(PULSE_CYCLES / 2 - PKT_LEN);
        send_pkt(8'h02, 8'hFF, 1'b0, 0);
        idle(PULSE_CYCLES + 5);
        check("retrig_width", 32'(last_run), 32'(PULSE_CYCLES / 2 + PULSE_CYCLES));

        // Reset mid-packet
        send_byte(SYNC, 2);
        send_byte(8'h0F, 2);
        tick(1'b0, 1'b0, 8'h00);
        check("midrst_ch", 32'(o_ch), 32'h0);
        check("midrst_cnt", 32'(o_err_cnt), 32'h0);
        check("midrst_trig", 32'(o_trigger), 32'h0);
        $display("reset mid-packet cycle=%0d", now);
        send_pkt(8'h06, 8'h00, 1'b0, 3);
        check("postrst_ch", 32'(o_ch), 32'h6);

        // Randomized traffic
        for (int t = 0; t < 150; t++) begin
            int kind;
            int gap;
            kind = $urandom_range(0, 9);
            gap  = $urandom_range(0, 12);
            case (kind)
                0: begin
                    send_byte(8'($urandom_range(0, 255)), gap);
                    $display("txn %0d garbage byte cycle=%0d", t, now);
                end
                1: begin
                    send_byte(SYNC, gap);
                    send_byte(8'($urandom_range(0, 255)), gap);
                    idle(BYTE_TIMEOUT + $urandom_range(0, 3));
                    $display("txn %0d partial packet cycle=%0d err_cnt=%0d", t, now, o_err_cnt);
                end
                2: begin
                    send_pkt(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0,
                             $urandom_range(BYTE_TIMEOUT - 2, BYTE_TIMEOUT + 2));
                end
                3: begin
                    idle($urandom_range(0, HOLD_CYCLES + 20));
                    $display("txn %0d silence cycle=%0d ch=%0h", t, now, o_ch);
                end
                4: begin
                    if ($urandom_range(0, 3) == 0) begin
                        tick(1'b0, 1'b0, 8'h00);
                        $display("txn %0d reset cycle=%0d", t, now);
                    end else begin
                        send_pkt(8'($urandom_range(0, 255)), 8'h01, 1'b0, gap);
                    end
                end
                default: begin
                    send_pkt(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                             ($urandom_range(0, 3) == 0), gap);
                end
            endcase
        end

        // Error counter saturation
        for (int k = 0; k < 260; k++) begin
            send_byte(SYNC, 2);
            send_byte(8'h0F, 0);
            idle(BYTE_TIMEOUT);
            $display("sat txn %0d cycle=%0d err_cnt=%0d", k, now, o_err_cnt);
        end
        check("err_cnt_sat", 32'(o_err_cnt), 32'd255);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    // Global time bound
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got cycle %0d, expected completion", now);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Parametrised successor to the board's single-byte UART direction decoder. Consumes the byte stream from the UART receiver (one-cycle `i_done` strobe plus `i_data`) and parses framed multi-byte command packets. Drives `NUM_CH` held channel outputs with a loss-of-link watchdog, a stretched trigger pulse, and error and status reporting. Sits between `uart_reciever` and the board LEDs/segment outputs in the top level.

## Interface
- `NUM_CH`, 4: number of held channel outputs, 1..8.
- `SYNC_BYTE`, 8'hA5: packet start marker.
- `BYTE_TIMEOUT`, 50000: maximum idle cycles between bytes inside a packet.
- `HOLD_CYCLES`, 2500000: cycles after which `o_ch` clears if no valid packet arrives.
- `PULSE_CYCLES`, 25000: `o_trigger` pulse width in cycles, ≥1.
- `i_clk`  in  1: single clock; all logic on its rising edge.
- `i_rst_n`  in  1: reset, synchronous, active-low.
- `i_done`  in  1: byte-valid strobe from the receiver, one cycle per byte.
- `i_data`  in  8: received byte; valid when `i_done`=1.
- `o_ch`  out  NUM_CH: held channel levels (right/left/up/down in the default build).
- `o_trigger`  out  1: stretched trigger pulse.
- `o_pkt_valid`  out  1: one-cycle strobe per accepted packet.
- `o_err`  out  1: one-cycle strobe per rejected or timed-out packet.
- `o_err_cnt`  out  8: saturating error count.

## Operation
- Packet format:
  - b0 = `SYNC_BYTE`.
  - b1 = channel mask; bits [NUM_CH-1:0] are used, upper bits are ignored.
  - b2 = flags; bit0 = trigger, bits 7:1 are reserved and ignored.
  - b3 = checksum, present only with `UART_CMD_CHECKSUM_EN`.
- FSM states: IDLE, MASK, FLAGS, CSUM.
  - IDLE: byte == `SYNC_BYTE` → MASK. Any other byte is dropped silently with no error.
  - MASK: byte → latch mask, go to FLAGS. `SYNC_BYTE` here is treated as data; there is no resync.
  - FLAGS: byte → latch flags. Without checksum: commit, go to IDLE. With checksum: go to CSUM.
  - CSUM: byte == (b1 ^ b2) → commit, go to IDLE. Mismatch → error, go to IDLE.
- Commit actions:
  - `o_ch` ← mask[NUM_CH-1:0].
  - Pulse `o_pkt_valid`.
  - Reload the hold timer.
  - If flags bit0 = 1, (re)load the trigger timer.
- Inter-byte timeout: a byte counter runs in MASK/FLAGS/CSUM and clears on every `i_done`. Reaching `BYTE_TIMEOUT` → error, go to IDLE.
- Error actions:
  - Pulse `o_err`.
  - `o_err_cnt` += 1, saturating at 255.
  - `o_ch` and `o_trigger` unchanged.
- Hold watchdog: counts cycles since the last commit. On reaching `HOLD_CYCLES`, `o_ch` ← 0 and the counter stops until the next commit. No error is flagged.
- Trigger: `o_trigger` is high for exactly `PULSE_CYCLES` cycles after a commit with flag bit0 set. A new trigger commit while the pulse is active restarts the full width.

## Timing
- Reset (`i_rst_n`=0 at an edge):
  - FSM → IDLE.
  - `o_ch`=0, `o_trigger`=0, `o_pkt_valid`=0, `o_err`=0, `o_err_cnt`=0.
  - All timers cleared and hold watchdog stopped.
  - Reset mid-packet discards the partial packet.
- Latency: on the edge sampling the final byte's `i_done`, all commit outputs register together. `o_ch`, `o_pkt_valid` and `o_trigger` are visible the cycle after the strobe.
- The error strobe follows the same one-cycle latency as the commit strobe.
- `o_pkt_valid` and `o_err` are never high in the same cycle.
- Timeout expiry and `i_done` in the same cycle: the byte wins; it is processed and the counter clears.
- Hold expiry and commit in the same cycle: the commit wins; `o_ch` takes the new mask.
- Trigger end and retrigger in the same cycle: `o_trigger` stays high with no gap.
- Counter widths are `$clog2(param+1)`. All counters are unsigned and do not wrap, except `o_err_cnt`, which saturates.

## Configuration
- `UART_CMD_CHECKSUM_EN` defined: 4-byte packets. CSUM state and XOR check are present; a mismatch is an error.
- Not defined: 3-byte packets. The CSUM state and checksum logic are removed; commit happens on b2.

## Structure
- Package `uart_cmd_pkg` holds:
  - the FSM state enum (IDLE/MASK/FLAGS/CSUM);
  - default `SYNC_BYTE`;
  - the flag bit index `FLAG_TRIG`=0;
  - `ERR_CNT_W`=8.
- One sub-module: `cycle_timer`, a loadable counter with a terminal-count output. It is instantiated three times: byte timeout, hold watchdog and trigger pulse.

## Test plan
- A5,05,01 (checksum build adds 04) at byte spacing 100 → `o_ch`=4'b0101 one cycle after the last strobe; `o_pkt_valid` 1 cycle; `o_trigger` high for exactly `PULSE_CYCLES`.
- Checksum build: A5,03,00,FF → `o_err`=1, `o_err_cnt`=1, `o_ch` unchanged; then a valid A5,03,00,03 → `o_ch`=4'b0011.
- A5,0F then a gap of `BYTE_TIMEOUT` cycles → `o_err` pulse, FSM in IDLE; a later 0F byte is dropped with no error.
- Valid packet, then silence for `HOLD_CYCLES` → `o_ch`→0 on the expiry cycle; a refresh packet at `HOLD_CYCLES`-1 keeps `o_ch` held.
- Two trigger packets spaced `PULSE_CYCLES`/2 → one continuous pulse ending `PULSE_CYCLES` after the second commit.
- `i_rst_n` low after A5,0F → all outputs 0, `o_err_cnt`=0; the next full packet decodes normally.
